// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode encodings, instruction field
// widths and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSN_W  = 8;
    localparam int OP_W    = 2;
    localparam int FIELD_W = 4;
    localparam int REG_W   = 2;

    localparam logic [OP_W-1:0] OP_LDI   = 2'b00;
    localparam logic [OP_W-1:0] OP_LOAD  = 2'b01;
    localparam logic [OP_W-1:0] OP_STORE = 2'b10;
    localparam logic [OP_W-1:0] OP_STOP  = 2'b11;

    // ST_WAIT is only reachable when single-step support is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/prog_counter.sv
// Wrapping program counter: counts 0..PC_MAX on inc, back to 0 after PC_MAX.
// clear is synchronous, active-high, and dominates inc.
module prog_counter
    import cpu_pkg::*;
#(
    parameter int PC_MAX = 31
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (inc) begin
            pc_d = (pc_q == PC_W'(PC_MAX)) ? '0 : pc_q + PC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (clear) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: drives the ROM address, latches the instruction and
// hands it to execute over valid/ready. Define FETCH_SINGLE_STEP_EN for step/WAIT.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_MAX = 31
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [INSN_W-1:0]  instruction,
    output logic [PC_W-1:0]    address,
    output logic [INSN_W-1:0]  ir,
    output logic [OP_W-1:0]    opcode,
    output logic [FIELD_W-1:0] field,
    output logic [REG_W-1:0]   reg_sel,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic               busy,
    output logic               halted
);

    state_e              state_q;
    state_e              state_d;
    logic [INSN_W-1:0]   ir_q;
    logic [INSN_W-1:0]   ir_d;
    logic                pc_inc;

    prog_counter #(
        .PC_MAX(PC_MAX)
    ) u_pc (
        .clk  (clk),
        .clear(clear),
        .inc  (pc_inc),
        .pc   (address)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = instruction;
                state_d = (instruction[INSN_W-1 -: OP_W] == OP_STOP) ? ST_HALT : ST_ISSUE;
            end
            ST_ISSUE: begin
                // The PC only advances on a completed handshake, so a STOP keeps its address.
                if (issue_ready) begin
                    pc_inc = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            ST_WAIT: begin
                if (step) state_d = ST_FETCH;
            end
`endif
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign ir          = ir_q;
    assign opcode      = ir_q[INSN_W-1 -: OP_W];
    assign field       = ir_q[REG_W +: FIELD_W];
    assign reg_sel     = ir_q[REG_W-1:0];
    assign issue_valid = (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALT);
`ifdef FETCH_SINGLE_STEP_EN
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
`else
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: decode vector table, issue
// scoreboard, and hand-written reset/backpressure/halt/wrap/step sequences.
module tb_fetch_sequencer;

`ifdef FETCH_SINGLE_STEP_EN
    localparam int WAIT_CYC = 1;
`else
    localparam int WAIT_CYC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (PC_MAX = 31)
    logic       clear, start, issue_ready;
    logic [7:0] instruction, address, ir;
    logic [1:0] opcode, reg_sel;
    logic [3:0] field;
    logic       issue_valid, busy, halted;
    logic [7:0] rom [0:255];
    assign instruction = rom[address];

    // Wrap DUT (PC_MAX = 3), ROM holds only LDI
    logic       clear_w, start_w, ready_w;
    logic [7:0] instruction_w, address_w, ir_w;
    logic [1:0] opcode_w, reg_sel_w;
    logic [3:0] field_w;
    logic       issue_valid_w, busy_w, halted_w;
    assign instruction_w = {6'b0, address_w[1:0]};

`ifdef FETCH_SINGLE_STEP_EN
    logic step, step_w;
`endif

    fetch_sequencer #(.PC_MAX(31)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
`ifdef FETCH_SINGLE_STEP_EN
        .step       (step),
`endif
        .instruction(instruction),
        .address    (address),
        .ir         (ir),
        .opcode     (opcode),
        .field      (field),
        .reg_sel    (reg_sel),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .busy       (busy),
        .halted     (halted)
    );

    fetch_sequencer #(.PC_MAX(3)) dut_w (
        .clk        (clk),
        .clear      (clear_w),
        .start      (start_w),
`ifdef FETCH_SINGLE_STEP_EN
        .step       (step_w),
`endif
        .instruction(instruction_w),
        .address    (address_w),
        .ir         (ir_w),
        .opcode     (opcode_w),
        .field      (field_w),
        .reg_sel    (reg_sel_w),
        .issue_valid(issue_valid_w),
        .issue_ready(ready_w),
        .busy       (busy_w),
        .halted     (halted_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Scoreboard: expected issued instructions, popped at each handshake.
    logic [7:0] sb_q[$];
    logic       mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !clear && issue_valid && issue_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_issue", 32'(ir), 32'hFFFF_FFFF);
            else check("sb_issue", 32'(ir), 32'(sb_q.pop_front()));
        end
    end

    typedef struct {
        logic [7:0] instr;
        logic [1:0] op;
        logic [3:0] fld;
        logic [1:0] rs;
        logic       stop;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int exp_addr[6];

        vecs[0] = '{8'h09, 2'd0, 4'd2,  2'd1, 1'b0};
        vecs[1] = '{8'h5D, 2'd1, 4'd7,  2'd1, 1'b0};
        vecs[2] = '{8'h8F, 2'd2, 4'd3,  2'd3, 1'b0};
        vecs[3] = '{8'h43, 2'd1, 4'd0,  2'd3, 1'b0};
        vecs[4] = '{8'h3C, 2'd0, 4'd15, 2'd0, 1'b0};
        vecs[5] = '{8'hB6, 2'd2, 4'd13, 2'd2, 1'b0};
        vecs[6] = '{8'hC7, 2'd3, 4'd1,  2'd3, 1'b1};
        exp_addr = '{0, 1, 2, 3, 0, 1};

        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
        rom[0] = 8'h09;
        clear = 1'b1; start = 1'b0; issue_ready = 1'b0;
        clear_w = 1'b1; start_w = 1'b0; ready_w = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b1; step_w = 1'b1;
`endif
        tick();
        clear = 1'b0; clear_w = 1'b0;

        // Reset state
        check("rst_address", 32'(address), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);

        // clear during an ISSUE whose handshake completes in the same cycle
        start = 1'b1; tick(); start = 1'b0; tick();
        check("rstmid_pre_valid", 32'(issue_valid), 1);
        issue_ready = 1'b1; clear = 1'b1; tick(); clear = 1'b0; issue_ready = 1'b0;
        check("rstmid_address", 32'(address), 0);
        check("rstmid_ir", 32'(ir), 0);
        check("rstmid_valid", 32'(issue_valid), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_halted", 32'(halted), 0);
        tick();
        check("rstmid_stays_idle", 32'(busy), 0);

        // Decode table: one instruction fetched from address 0
        for (int i = 0; i < 7; i++) begin
            do_clear();
            rom[0] = vecs[i].instr;
            start = 1'b1; tick(); start = 1'b0;
            check($sformatf("tbl%0d_fetch_busy", i), 32'(busy), 1);
            check($sformatf("tbl%0d_fetch_valid", i), 32'(issue_valid), 0);
            check($sformatf("tbl%0d_fetch_addr", i), 32'(address), 0);
            tick();
            check($sformatf("tbl%0d_ir", i), 32'(ir), 32'(vecs[i].instr));
            check($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
            check($sformatf("tbl%0d_field", i), 32'(field), 32'(vecs[i].fld));
            check($sformatf("tbl%0d_reg", i), 32'(reg_sel), 32'(vecs[i].rs));
            check($sformatf("tbl%0d_valid", i), 32'(issue_valid), 32'(!vecs[i].stop));
            check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(vecs[i].stop));
        end

        // Program run with issue_ready held high; STOP must not issue
        do_clear();
        rom[0] = 8'h09; rom[1] = 8'h5D; rom[2] = 8'h8F; rom[3] = 8'h43; rom[4] = 8'hC3;
        sb_q.delete();
        sb_q.push_back(8'h09); sb_q.push_back(8'h5D);
        sb_q.push_back(8'h8F); sb_q.push_back(8'h43);
        mon_en = 1'b1; issue_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 60) begin
            tick();
            cyc++;
        end
        check("prog_halted", 32'(halted), 1);
        check("prog_cycles", 32'(cyc), 32'(9 + 4 * WAIT_CYC));
        check("prog_address", 32'(address), 4);
        check("prog_ir_stop", 32'(ir), 32'h0000_00C3);
        repeat (3) tick();
        check("prog_sb_drained", 32'(sb_q.size()), 0);
        mon_en = 1'b0; issue_ready = 1'b0;

        // Backpressure: 5 cycles of issue_ready low in ISSUE
        do_clear();
        sb_q.delete();
        sb_q.push_back(8'h09);
        mon_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(issue_valid), 1);
            check($sformatf("bp%0d_ir", k), 32'(ir), 32'h09);
            check($sformatf("bp%0d_address", k), 32'(address), 0);
            tick();
        end
        check("bp_final_valid", 32'(issue_valid), 1);
        issue_ready = 1'b1; tick(); issue_ready = 1'b0;
        check("bp_after_hs_address", 32'(address), 1);
        check("bp_after_hs_valid", 32'(issue_valid), 0);
        repeat (WAIT_CYC) tick();
        tick();
        check("bp_next_valid", 32'(issue_valid), 1);
        check("bp_next_ir", 32'(ir), 32'h5D);
        check("bp_next_address", 32'(address), 1);
        check("bp_sb_drained", 32'(sb_q.size()), 0);
        mon_en = 1'b0;

        // HALT is absorbing; clear + start restarts from address 0
        do_clear();
        rom[1] = 8'hC3;
        issue_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!halted && cyc < 20) begin
            tick();
            cyc++;
        end
        check("halt_reached", 32'(halted), 1);
        check("halt_address", 32'(address), 1);
        for (int k = 0; k < 4; k++) begin
            start = k[0];
            issue_ready = ~k[0];
            tick();
            check($sformatf("halt%0d_halted", k), 32'(halted), 1);
            check($sformatf("halt%0d_address", k), 32'(address), 1);
            check($sformatf("halt%0d_busy", k), 32'(busy), 0);
            check($sformatf("halt%0d_valid", k), 32'(issue_valid), 0);
            check($sformatf("halt%0d_ir", k), 32'(ir), 32'hC3);
        end
        start = 1'b0; issue_ready = 1'b0;
        do_clear();
        check("restart_clear_address", 32'(address), 0);
        check("restart_clear_halted", 32'(halted), 0);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_fetch_busy", 32'(busy), 1);
        check("restart_fetch_address", 32'(address), 0);
        tick();
        check("restart_issue_valid", 32'(issue_valid), 1);
        check("restart_issue_ir", 32'(ir), 32'h09);

        // Wrap with PC_MAX = 3: addresses seen at each issue
        ready_w = 1'b1;
        start_w = 1'b1; tick(); start_w = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 40) begin
            if (issue_valid_w) begin
                check($sformatf("wrap%0d_address", n), 32'(address_w), 32'(exp_addr[n]));
                check($sformatf("wrap%0d_ir", n), 32'(ir_w), 32'(exp_addr[n]));
                check($sformatf("wrap%0d_decode", n), {26'd0, opcode_w, field_w}, 0);
                check($sformatf("wrap%0d_reg", n), 32'(reg_sel_w), 32'(exp_addr[n]));
                n++;
            end
            tick();
            cyc++;
        end
        check("wrap_count", 32'(n), 6);
        check("wrap_not_halted", 32'(halted_w), 0);
        check("wrap_busy", 32'(busy_w), 1);
        ready_w = 1'b0;

`ifdef FETCH_SINGLE_STEP_EN
        // Single step: WAIT after each handshake until step, FETCH one cycle after
        do_clear();
        rom[0] = 8'h09; rom[1] = 8'h5D; rom[2] = 8'hC3;
        step = 1'b0; issue_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("ss_issue0_ir", 32'(ir), 32'h09);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ss_wait%0d_valid", k), 32'(issue_valid), 0);
            check($sformatf("ss_wait%0d_busy", k), 32'(busy), 1);
            check($sformatf("ss_wait%0d_address", k), 32'(address), 1);
            tick();
        end
        step = 1'b1; tick(); step = 1'b0;
        check("ss_fetch_valid", 32'(issue_valid), 0);
        check("ss_fetch_busy", 32'(busy), 1);
        tick();
        check("ss_issue1_valid", 32'(issue_valid), 1);
        check("ss_issue1_ir", 32'(ir), 32'h5D);
        issue_ready = 1'b0; step = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch/issue sequencer for the 8-bit CPU. Drives `address` into the instruction ROM and captures the returned `instruction` into an instruction register. Splits the instruction into opcode/field/register and hands it to the execute stage over a valid/ready handshake. Stops fetching on a STOP opcode and holds until reset.

## Interface
Parameters:
- `PC_MAX`, default 31: highest ROM address; the PC wraps to 0 after it.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins fetching from the current PC.
- `instruction`  in  8  combinational ROM data for `address`.
- `address`  out  8  ROM address; equals the PC, zero-extended.
- `ir`  out  8  latched instruction register.
- `opcode`  out  2  `ir[7:6]`.
- `field`  out  4  `ir[5:2]`: immediate value or memory address.
- `reg_sel`  out  2  `ir[1:0]`: destination/source register.
- `issue_valid`  out  1  `ir` holds an instruction for the execute stage.
- `issue_ready`  in  1  execute stage accepts `ir` this cycle.
- `busy`  out  1  high in FETCH or ISSUE.
- `halted`  out  1  high in HALT.

## Operation
- Opcodes:
  - `00` LDI: reg ← field.
  - `01` LOAD: reg ← mem[field].
  - `10` STORE: mem[field] ← reg.
  - `11` STOP.
- Only STOP is interpreted here; the other opcodes are passed through.
- States and transitions:
  - IDLE: `start` → FETCH.
  - FETCH (one cycle): `address` = PC.
    - At the edge, `ir` ← `instruction`.
    - If `instruction[7:6]` = `11` → HALT with PC unchanged.
    - Otherwise → ISSUE.
  - ISSUE: `issue_valid` = 1, and `ir` is held stable.
    - On an edge with `issue_ready` = 1: PC ← PC+1 (or 0 if PC = `PC_MAX`), then → FETCH.
    - With `issue_ready` = 0, stay in ISSUE indefinitely.
  - HALT: absorbing. `start` and `issue_ready` are ignored; only `clear` leaves it.
- STOP is never issued to the execute stage.
- PC arithmetic is 8-bit; values above `PC_MAX` are unreachable.
- A `start` pulse in any state other than IDLE is ignored.
- `issue_ready` outside ISSUE is ignored.

## Timing
- Reset: on a `clear` edge, all of the following are forced:
  - PC = 0, `address` = 0, `ir` = 0 (so `opcode`/`field`/`reg_sel` = 0).
  - `issue_valid` = 0, `busy` = 0, `halted` = 0.
  - State → IDLE.
- `clear` has priority over every other input and aborts any state, including an ISSUE whose handshake completes in the same cycle (that PC increment is discarded).
- `start` at edge N:
  - FETCH during cycle N+1.
  - `issue_valid` high from cycle N+2.
- Minimum 2 cycles per instruction when `issue_ready` is held high.
- `address` changes only on the edge that leaves ISSUE; it is stable for the whole FETCH cycle.
- `opcode`/`field`/`reg_sel` are combinational from `ir`.
- `halted` rises the cycle after the FETCH that sees STOP.

## Configuration
- `FETCH_SINGLE_STEP_EN` defined:
  - Adds input `step` (1 bit) and a WAIT state.
  - A completed ISSUE handshake goes to WAIT instead of FETCH; WAIT → FETCH on `step` = 1.
  - `busy` = 1 in WAIT.
- Undefined: no `step` port and no WAIT state; ISSUE goes directly to FETCH.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants `OP_LDI`, `OP_LOAD`, `OP_STORE`, `OP_STOP`.
  - State enum.
  - Field-slice widths (2/4/2).
- One sub-module, `prog_counter`: wrapping PC register with `clear`, `inc`, and parameter `PC_MAX`.
- The sequencer FSM, `ir` latch and decode stay in the top module.

## Test plan
- Reset mid-ISSUE, then `clear` → next cycle:
  - `address` = 0, `ir` = 0, `issue_valid` = 0, `busy` = 0, `halted` = 0, state IDLE.
- ROM {0x09, 0x5D, 0x8F, 0x43, 0xC3}, `start`, `issue_ready` = 1:
  - Issues, in order: 0x09 (op 0, field 2, reg 1), 0x5D, 0x8F, 0x43.
  - Then `halted` = 1 with `address` = 4; 0xC3 is never issued.
- Backpressure: `issue_ready` = 0 for 5 cycles during ISSUE:
  - `issue_valid` stays 1, and `ir` and `address` hold.
  - One handshake follows → `address` increments by exactly 1.
- Wrap: `PC_MAX` = 3, ROM with no STOP:
  - Addresses sequence 0, 1, 2, 3, 0, 1.
- HALT robustness: `start` and `issue_ready` pulses while halted → no change.
  - Then `clear` + `start` restarts fetching from address 0.
- With `FETCH_SINGLE_STEP_EN`:
  - After each handshake `issue_valid` = 0 and `busy` = 1 until `step`.
  - FETCH occurs exactly 1 cycle after `step`.
